// File: rtl/core_msg_receiver_pkg.sv
// Shared scheduler-bus definitions for the per-core message receiver:
// bus width, r0 header length, loading-flag positions and receiver states.
package core_msg_receiver_pkg;

    localparam int SCHED_MSG_BUS_WIDTH = 16;
    localparam int SCHED_R0_WORDS      = 8;

    localparam int NUM_FLAGS      = 4;
    localparam int FLAG_CORE_MASK = 0;
    localparam int FLAG_R0_MASK   = 1;
    localparam int FLAG_R0        = 2;
    localparam int FLAG_INSTR     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_R0   = 2'd2,
        ST_RUN  = 2'd3
    } rcv_state_e;

    // True when more than one loading flag qualifies the same bus word.
    function automatic logic flags_multi(input logic [NUM_FLAGS-1:0] flags);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            n = n + {2'd0, flags[i]};
        end
        return (n > 3'd1);
    endfunction

endpackage

// File: rtl/core_msg_receiver_if.sv
// Scheduler->core message bus: one data word, four qualifying flags, and the
// per-core handshake bits returned to the scheduler.
interface core_msg_receiver_if #(
    parameter int BUS_WIDTH = 16
) ();
    logic [BUS_WIDTH-1:0] mess_to_core;
    logic                 core_mask_loading;
    logic                 r0_mask_loading;
    logic                 r0_loading;
    logic                 instr_loading;
    logic                 core_reading;
    logic                 core_ready;

    modport master (
        output mess_to_core, core_mask_loading, r0_mask_loading, r0_loading, instr_loading,
        input  core_reading, core_ready
    );

    modport slave (
        input  mess_to_core, core_mask_loading, r0_mask_loading, r0_loading, instr_loading,
        output core_reading, core_ready
    );
endinterface

// File: rtl/core_msg_receiver_rcv_instr_buf.sv
// Instruction buffer: one write port and one registered read port; a read of the
// address being written in the same cycle returns the new word.
module rcv_instr_buf #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array; deliberately not reset, validity is tracked by the caller's count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read with write-first bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_r[rd_addr];
        end else begin
            rd_data <= rd_data;
        end
    end
endmodule

// File: rtl/core_msg_receiver.sv
// Per-core receiver for scheduler messages: decodes the task header, captures this
// core's instruction stream and drives the core_reading/core_ready handshake.
module core_msg_receiver
    import core_msg_receiver_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = 16,
    parameter int BUS_WIDTH  = SCHED_MSG_BUS_WIDTH,
    parameter int R0_WORDS   = SCHED_R0_WORDS,
    parameter int IBUF_DEPTH = 256,
    parameter int AW         = $clog2(IBUF_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    core_msg_receiver_if.slave   bus,
    input  logic                 exec_done,
    input  logic                 fetch_en,
    input  logic [AW-1:0]        fetch_addr,
    output logic                 task_start,
    output logic                 r0_init,
    output logic [BUS_WIDTH-1:0] r0_value,
    output logic [BUS_WIDTH-1:0] fetch_data,
    output logic                 fetch_valid,
    output logic [AW:0]          instr_count,
    output logic                 protocol_err
);
    localparam int           KW       = $clog2(R0_WORDS) + 1;
    localparam logic [KW-1:0] K_LAST  = KW'(R0_WORDS - 1);
    localparam logic [KW-1:0] K_OWN   = KW'(CORE_ID % R0_WORDS);
    localparam logic [AW:0]  CNT_FULL = (AW + 1)'(IBUF_DEPTH);

    rcv_state_e           state_r, state_s;
    logic [KW-1:0]        k_r, k_s;
    logic                 r0_sel_r, r0_sel_s;
    logic                 capture_r, capture_s;
    logic                 r0_init_s, task_start_s, err_s;
    logic [BUS_WIDTH-1:0] r0_value_s;
    logic [AW:0]          count_s;
    logic                 wr_en_s;
    logic                 core_reading_r, core_ready_r;
    logic [NUM_FLAGS-1:0] flags_s;
    logic                 single_s, own_bit_s;

    assign flags_s   = {bus.instr_loading, bus.r0_loading, bus.r0_mask_loading, bus.core_mask_loading};
    assign single_s  = !flags_multi(flags_s);
    assign own_bit_s = bus.mess_to_core[CORE_ID % CORE_NUM];

    assign bus.core_reading = core_reading_r;
    assign bus.core_ready   = core_ready_r;

    // Next-state and datapath decode; a multi-flag word only raises the error.
    always_comb begin
        state_s      = state_r;
        k_s          = k_r;
        r0_sel_s     = r0_sel_r;
        capture_s    = capture_r;
        r0_init_s    = r0_init;
        r0_value_s   = r0_value;
        count_s      = instr_count;
        task_start_s = 1'b0;
        wr_en_s      = 1'b0;
        err_s        = protocol_err | !single_s;
        case (state_r)
            ST_IDLE: begin
                if (single_s && flags_s[FLAG_CORE_MASK] && own_bit_s) begin
                    state_s    = ST_HDR;
                    count_s    = '0;
                    k_s        = '0;
                    r0_init_s  = 1'b0;
                    r0_value_s = '0;
                    capture_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (single_s && flags_s[FLAG_R0_MASK]) begin
                    state_s  = ST_R0;
                    r0_sel_s = own_bit_s;
                end else if (single_s && (flags_s[FLAG_R0] || flags_s[FLAG_INSTR])) begin
                    err_s = 1'b1;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_R0: begin
                if (single_s && flags_s[FLAG_R0]) begin
                    if (r0_sel_r && (k_r == K_OWN)) begin
                        r0_value_s = bus.mess_to_core;
                        r0_init_s  = 1'b1;
                    end else begin
                        r0_init_s  = r0_init;
                    end
                    k_s = k_r + KW'(1);
                    if (k_r == K_LAST) begin
                        state_s      = ST_RUN;
                        task_start_s = 1'b1;
                    end else begin
                        state_s = ST_R0;
                    end
                end else begin
                    state_s = ST_R0;
                end
            end
            ST_RUN: begin
                if (single_s && flags_s[FLAG_INSTR] && capture_r) begin
                    if (instr_count == CNT_FULL) begin
                        err_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b1;
                        count_s = instr_count + (AW + 1)'(1);
                    end
                end else if (single_s && flags_s[FLAG_CORE_MASK]) begin
                    // Own bit here means the scheduler reissued us while busy.
                    if (own_bit_s) begin
                        err_s = 1'b1;
                    end else begin
                        capture_s = 1'b0;
                    end
                end else begin
                    capture_s = capture_r;
                end
                if (exec_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            k_r            <= '0;
            r0_sel_r       <= 1'b0;
            capture_r      <= 1'b0;
            r0_init        <= 1'b0;
            r0_value       <= '0;
            instr_count    <= '0;
            task_start     <= 1'b0;
            protocol_err   <= 1'b0;
            fetch_valid    <= 1'b0;
            core_ready_r   <= 1'b1;
            core_reading_r <= 1'b1;
        end else begin
            state_r        <= state_s;
            k_r            <= k_s;
            r0_sel_r       <= r0_sel_s;
            capture_r      <= capture_s;
            r0_init        <= r0_init_s;
            r0_value       <= r0_value_s;
            instr_count    <= count_s;
            task_start     <= task_start_s;
            protocol_err   <= err_s;
            fetch_valid    <= fetch_en && ({1'b0, fetch_addr} < instr_count);
            core_ready_r   <= (state_s == ST_IDLE);
            core_reading_r <= !((state_s == ST_RUN) && capture_s && (count_s == CNT_FULL));
        end
    end

    rcv_instr_buf #(
        .DEPTH (IBUF_DEPTH),
        .WIDTH (BUS_WIDTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (instr_count[AW-1:0]),
        .wr_data (bus.mess_to_core),
        .rd_en   (fetch_en),
        .rd_addr (fetch_addr),
        .rd_data (fetch_data)
    );
endmodule

// File: tb/tb_core_msg_receiver.sv
// Directed plus randomized bench: two receivers (core 3 / 256 entries, core 10 / 16 entries)
// share one bus and are compared every cycle against a task-level reference model.
module tb_core_msg_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] word = 16'h0000;
    logic        f_cm = 1'b0, f_rm = 1'b0, f_r0 = 1'b0, f_in = 1'b0;
    logic        exd = 1'b0, fen = 1'b0;
    logic [7:0]  faddr = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_msg_receiver_if bus_a ();
    core_msg_receiver_if bus_b ();

    assign bus_a.mess_to_core = word;      assign bus_b.mess_to_core = word;
    assign bus_a.core_mask_loading = f_cm; assign bus_b.core_mask_loading = f_cm;
    assign bus_a.r0_mask_loading = f_rm;   assign bus_b.r0_mask_loading = f_rm;
    assign bus_a.r0_loading = f_r0;        assign bus_b.r0_loading = f_r0;
    assign bus_a.instr_loading = f_in;     assign bus_b.instr_loading = f_in;

    logic        ts_a, ri_a, fv_a, err_a, ts_b, ri_b, fv_b, err_b;
    logic [15:0] rv_a, fd_a, rv_b, fd_b;
    logic [8:0]  cnt_a;
    logic [4:0]  cnt_b;

    core_msg_receiver #(.CORE_ID(3), .CORE_NUM(16), .BUS_WIDTH(16), .R0_WORDS(8), .IBUF_DEPTH(256)) dut_a (
        .clk(clk), .reset(rst), .bus(bus_a), .exec_done(exd), .fetch_en(fen), .fetch_addr(faddr),
        .task_start(ts_a), .r0_init(ri_a), .r0_value(rv_a), .fetch_data(fd_a), .fetch_valid(fv_a),
        .instr_count(cnt_a), .protocol_err(err_a));

    core_msg_receiver #(.CORE_ID(10), .CORE_NUM(16), .BUS_WIDTH(16), .R0_WORDS(8), .IBUF_DEPTH(16)) dut_b (
        .clk(clk), .reset(rst), .bus(bus_b), .exec_done(exd), .fetch_en(fen), .fetch_addr(faddr[3:0]),
        .task_start(ts_b), .r0_init(ri_b), .r0_value(rv_b), .fetch_data(fd_b), .fetch_valid(fv_b),
        .instr_count(cnt_b), .protocol_err(err_b));

    // Reference model: phase 0 idle, 1 header, 2 r0 words, 3 running.
    int cid [2] = '{3, 10};
    int dep [2] = '{256, 16};
    int m_ph [2], m_k [2], m_cnt [2], m_rv [2], m_fd [2];
    bit m_sel [2], m_cap [2], m_err [2], m_ri [2], m_ts [2], m_rdy [2], m_rdg [2], m_fv [2], m_fdk [2];
    int mem [2][256];
    bit known [2][256];

    task automatic model_update(input int d);
        int ph, a, nf;
        bit own;
        if (rst) begin
            m_ph[d] = 0; m_k[d] = 0; m_cnt[d] = 0; m_rv[d] = 0; m_fd[d] = 0; m_fdk[d] = 1;
            m_sel[d] = 0; m_cap[d] = 0; m_err[d] = 0; m_ri[d] = 0; m_ts[d] = 0;
            m_rdy[d] = 1; m_rdg[d] = 1; m_fv[d] = 0;
            return;
        end
        ph  = m_ph[d];
        own = word[cid[d]];
        a   = int'(faddr) % dep[d];
        nf  = int'(f_cm) + int'(f_rm) + int'(f_r0) + int'(f_in);
        m_ts[d] = 0;
        m_fv[d] = fen && (a < m_cnt[d]);
        if (nf > 1) m_err[d] = 1;
        else if (nf == 1) begin
            if (ph == 0 && f_cm && own) begin
                m_ph[d] = 1; m_cnt[d] = 0; m_k[d] = 0; m_ri[d] = 0; m_rv[d] = 0; m_cap[d] = 1;
            end else if (ph == 1) begin
                if (f_rm) begin m_ph[d] = 2; m_sel[d] = own; end
                else if (f_r0 || f_in) m_err[d] = 1;
            end else if (ph == 2 && f_r0) begin
                if (m_sel[d] && m_k[d] == cid[d] % 8) begin m_rv[d] = int'(word); m_ri[d] = 1; end
                m_k[d]++;
                if (m_k[d] == 8) begin m_ph[d] = 3; m_ts[d] = 1; end
            end else if (ph == 3) begin
                if (f_in && m_cap[d]) begin
                    if (m_cnt[d] == dep[d]) m_err[d] = 1;
                    else begin
                        mem[d][m_cnt[d]] = int'(word); known[d][m_cnt[d]] = 1; m_cnt[d]++;
                    end
                end else if (f_cm) begin
                    if (own) m_err[d] = 1; else m_cap[d] = 0;
                end
            end
        end
        if (ph == 3 && exd) m_ph[d] = 0;
        if (fen) begin m_fd[d] = mem[d][a]; m_fdk[d] = known[d][a]; end
        m_rdy[d] = (m_ph[d] == 0);
        m_rdg[d] = !(m_ph[d] == 3 && m_cap[d] && m_cnt[d] == dep[d]);
    endtask

    task automatic cmp(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_dut(input int d, input logic ts, input logic ri, input logic [15:0] rv,
                           input logic [15:0] fd, input logic fv, input logic [31:0] cnt,
                           input logic err, input logic rdy, input logic rdg);
        cmp("task_start", d, 32'(ts), 32'(m_ts[d]));
        cmp("r0_init", d, 32'(ri), 32'(m_ri[d]));
        cmp("r0_value", d, 32'(rv), 32'(m_rv[d]));
        cmp("fetch_valid", d, 32'(fv), 32'(m_fv[d]));
        if (m_fdk[d]) cmp("fetch_data", d, 32'(fd), 32'(m_fd[d]));
        cmp("instr_count", d, cnt, 32'(m_cnt[d]));
        cmp("protocol_err", d, 32'(err), 32'(m_err[d]));
        cmp("core_ready", d, 32'(rdy), 32'(m_rdy[d]));
        cmp("core_reading", d, 32'(rdg), 32'(m_rdg[d]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        chk_dut(0, ts_a, ri_a, rv_a, fd_a, fv_a, 32'(cnt_a), err_a, bus_a.core_ready, bus_a.core_reading);
        chk_dut(1, ts_b, ri_b, rv_b, fd_b, fv_b, 32'(cnt_b), err_b, bus_b.core_ready, bus_b.core_reading);
        exd = 1'b0;
        fen = 1'b0;
    endtask

    // kind: 0 core mask, 1 r0 mask, 2 r0 word, 3 instruction
    task automatic send(input int kind, input logic [15:0] w);
        word = w;
        f_cm = (kind == 0); f_rm = (kind == 1); f_r0 = (kind == 2); f_in = (kind == 3);
        step();
        {f_cm, f_rm, f_r0, f_in} = 4'b0000;
    endtask

    task automatic header(input logic [15:0] mask, input logic [15:0] r0mask);
        send(0, mask);
        send(1, r0mask);
        for (int i = 0; i < 8; i++) send(2, 16'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        step(); step();
        cmp("rst_ready", 0, 32'(bus_a.core_ready), 32'd1);
        cmp("rst_reading", 0, 32'(bus_a.core_reading), 32'd1);
        cmp("rst_fetch_data", 0, 32'(fd_a), 32'd0);
        cmp("rst_count", 0, 32'(cnt_a), 32'd0);
        rst = 1'b0;
        step();

        // Test 1: core 3 owns r0 word index 3.
        send(0, 16'h0008);
        cmp("t1_busy_on_mask", 0, 32'(bus_a.core_ready), 32'd0);
        send(1, 16'h0008);
        for (int i = 0; i < 8; i++) send(2, 16'(16'h0010 + i));
        cmp("t1_task_start", 0, 32'(ts_a), 32'd1);
        cmp("t1_r0_init", 0, 32'(ri_a), 32'd1);
        cmp("t1_r0_value", 0, 32'(rv_a), 32'h13);
        step();
        cmp("t1_start_pulse", 0, 32'(ts_a), 32'd0);
        exd = 1'b1; step(); step();

        // Test 2: no r0 for us, 16 instructions; same-cycle read of the write address.
        header(16'h0408, 16'h0000);
        cmp("t2_r0_init", 0, 32'(ri_a), 32'd0);
        cmp("t2_r0_value", 0, 32'(rv_a), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin fen = 1'b1; faddr = 8'd7; end
            send(3, 16'(16'hA000 + i));
            if (i == 7) cmp("t2_bypass", 0, 32'(fd_a), 32'hA007);
        end
        cmp("t2_count", 0, 32'(cnt_a), 32'd16);
        fen = 1'b1; faddr = 8'd5; step();
        cmp("t2_fetch5", 0, 32'(fd_a), 32'hA005);
        cmp("t2_fetch5_valid", 0, 32'(fv_a), 32'd1);
        fen = 1'b1; faddr = 8'd16; step();
        cmp("t2_fetch16_valid", 0, 32'(fv_a), 32'd0);
        exd = 1'b1; step(); step();

        // Test 3: header addressed elsewhere is ignored entirely.
        header(16'h0001, 16'hFFFF);
        for (int i = 0; i < 4; i++) send(3, 16'($urandom));
        cmp("t3_ready", 0, 32'(bus_a.core_ready), 32'd1);
        cmp("t3_err", 0, 32'(err_a), 32'd0);

        // Test 4: next task's instructions are not captured; exec_done releases.
        header(16'h0408, 16'($urandom) | 16'h0408);
        for (int i = 0; i < 3; i++) send(3, 16'($urandom));
        send(0, 16'h00F0);
        for (int i = 0; i < 4; i++) send(3, 16'($urandom));
        cmp("t4_count", 0, 32'(cnt_a), 32'd3);
        exd = 1'b1; step();
        cmp("t4_ready", 0, 32'(bus_a.core_ready), 32'd1);

        // Test 5: overflow of the 16-entry receiver.
        header(16'h0408, 16'h0400);
        for (int i = 0; i < 16; i++) send(3, 16'($urandom));
        cmp("t5_reading", 1, 32'(bus_b.core_reading), 32'd0);
        cmp("t5_err_before", 1, 32'(err_b), 32'd0);
        send(3, 16'($urandom));
        cmp("t5_err", 1, 32'(err_b), 32'd1);
        cmp("t5_count_sat", 1, 32'(cnt_b), 32'd16);
        exd = 1'b1; step();
        cmp("t5_reading_back", 1, 32'(bus_b.core_reading), 32'd1);

        // Two flags at once are a protocol error.
        word = 16'($urandom); f_rm = 1'b1; f_in = 1'b1; step(); {f_rm, f_in} = 2'b00;
        cmp("multi_flag_err", 0, 32'(err_a), 32'd1);

        // Test 6: reset in the middle of the r0 words, then a fresh header.
        send(0, 16'h0408); send(1, 16'h0408);
        for (int i = 0; i < 4; i++) send(2, 16'($urandom));
        rst = 1'b1; step(); rst = 1'b0;
        cmp("t6_ready", 0, 32'(bus_a.core_ready), 32'd1);
        cmp("t6_err", 0, 32'(err_a), 32'd0);
        cmp("t6_r0_value", 0, 32'(rv_a), 32'd0);
        send(0, 16'h0008);
        cmp("t6_fresh_hdr", 0, 32'(bus_a.core_ready), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            word = 16'($urandom);
            if ($urandom_range(0, 1) == 1) word = word | 16'h0408;
            {f_cm, f_rm, f_r0, f_in} = 4'b0000;
            if (r < 8) f_cm = 1'b1;
            else if (r < 14) f_rm = 1'b1;
            else if (r < 40) f_r0 = 1'b1;
            else if (r < 80) f_in = 1'b1;
            else if (r < 82) {f_cm, f_in} = 2'b11;
            exd = ($urandom_range(0, 99) < 3);
            fen = ($urandom_range(0, 1) == 1);
            faddr = 8'($urandom_range(0, 40));
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        {f_cm, f_rm, f_r0, f_in} = 4'b0000;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
